// File: rtl/countdown_timer.sv
// countdown_timer: two-digit BCD countdown (00..99 seconds) with load,
// start/resume and pause controls, driven by a CLOCK_FREQUENCY divider.
// Optional feature: define COUNTDOWN_WARN_EN to enable the low-time
// Warning output; without it Warning is tied low.
module countdown_timer #(
  parameter int CLOCK_FREQUENCY = 50000000
) (
  input  logic       ClockIn,
  input  logic       Resetn,
  input  logic       Load,
  input  logic [3:0] LoadTens,
  input  logic [3:0] LoadOnes,
  input  logic       Start,
  input  logic       Pause,
  output logic [3:0] OnesValue,
  output logic [3:0] TensValue,
  output logic       Running,
  output logic       Expired,
  output logic       ExpirePulse,
  output logic       Warning
);

  localparam int DIV_W = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_FREQUENCY - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic [3:0]       ones_next;
  logic [3:0]       tens_next;
  logic             running_next;
  logic             expired_next;
  logic             pulse_next;
  logic             tick;
  logic             last_second;
  logic             value_nonzero;

  // Digits above 9 are not legal BCD; saturate them to 9.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // A Pause edge in RUN freezes the divider, so it never ticks on that edge.
  assign tick          = (state == RUN) && !Pause && (div == DIV_LAST);
  assign last_second   = (TensValue == 4'd0) && (OnesValue == 4'd1);
  assign value_nonzero = (TensValue != 4'd0) || (OnesValue != 4'd0);

  // State register.
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic: Load beats Start; only controls meaningful in the
  // current state take part (RUN ignores Load and Start).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (Load)                        state_next = IDLE;
        else if (Start && value_nonzero) state_next = RUN;
      end
      PAUSE: begin
        if (Load)                        state_next = IDLE;
        else if (Start && value_nonzero) state_next = RUN;
      end
      RUN: begin
        if (Pause)                       state_next = PAUSE;
        else if (tick && last_second)    state_next = EXPIRED;
      end
      EXPIRED: begin
        if (Load)                        state_next = IDLE;
      end
    endcase
  end

  // Output/datapath logic: next digit, divider and status values.
  always_comb begin
    div_next  = div;
    ones_next = OnesValue;
    tens_next = TensValue;
    if ((state != RUN) && Load) begin
      div_next  = '0;
      ones_next = clamp_bcd(LoadOnes);
      tens_next = clamp_bcd(LoadTens);
    end else if ((state == RUN) && !Pause) begin
      div_next = tick ? '0 : (div + DIV_ONE);
      if (tick) begin
        if (OnesValue != 4'd0) begin
          ones_next = OnesValue - 4'd1;
        end else if (TensValue != 4'd0) begin
          ones_next = 4'd9;
          tens_next = TensValue - 4'd1;
        end
      end
    end
    running_next = (state_next == RUN);
    expired_next = (state_next == EXPIRED);
    pulse_next   = (state == RUN) && (state_next == EXPIRED);
  end

  // Registered digits, divider and state decodes.
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      div         <= '0;
      OnesValue   <= 4'd0;
      TensValue   <= 4'd0;
      Running     <= 1'b0;
      Expired     <= 1'b0;
      ExpirePulse <= 1'b0;
    end else begin
      div         <= div_next;
      OnesValue   <= ones_next;
      TensValue   <= tens_next;
      Running     <= running_next;
      Expired     <= expired_next;
      ExpirePulse <= pulse_next;
    end
  end

`ifdef COUNTDOWN_WARN_EN
  logic warning_next;

  assign warning_next = ((state_next == RUN) || (state_next == PAUSE)) &&
                        (tens_next == 4'd0);

  // Low-time indicator, aligned with the registered state and digits.
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) Warning <= 1'b0;
    else         Warning <= warning_next;
  end
`else
  assign Warning = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench for countdown_timer (CLOCK_FREQUENCY=4).
// A seconds-level reference model predicts each cycle's outputs; a monitor
// compares them against the DUT on the falling edge.
module tb_countdown_timer;

  localparam int CF = 4;

  localparam int M_IDLE    = 0;
  localparam int M_RUN     = 1;
  localparam int M_PAUSE   = 2;
  localparam int M_EXPIRED = 3;

`ifdef COUNTDOWN_WARN_EN
  localparam bit WARN_EN = 1'b1;
`else
  localparam bit WARN_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       expired;
    logic       pulse;
    logic       warning;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_tens = 4'd0;
  logic [3:0] load_ones = 4'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] ones_value;
  logic [3:0] tens_value;
  logic       running;
  logic       expired;
  logic       expire_pulse;
  logic       warning;

  int checks = 0;
  int errors = 0;

  obs_t exp_q[$];

  // Reference model state: whole seconds remaining and cycles elapsed
  // within the current second.
  int secs  = 0;
  int phase = 0;
  int mode  = M_IDLE;
  bit pulse_m = 1'b0;

  countdown_timer #(.CLOCK_FREQUENCY(CF)) dut (
    .ClockIn    (clk),
    .Resetn     (rst_n),
    .Load       (load),
    .LoadTens   (load_tens),
    .LoadOnes   (load_ones),
    .Start      (start),
    .Pause      (pause),
    .OnesValue  (ones_value),
    .TensValue  (tens_value),
    .Running    (running),
    .Expired    (expired),
    .ExpirePulse(expire_pulse),
    .Warning    (warning)
  );

  always #5 clk = ~clk;

  function automatic obs_t dut_obs();
    obs_t o;
    o.tens    = tens_value;
    o.ones    = ones_value;
    o.running = running;
    o.expired = expired;
    o.pulse   = expire_pulse;
    o.warning = warning;
    return o;
  endfunction

  task automatic compare(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got tens=%0d ones=%0d run=%0b exp=%0b pulse=%0b warn=%0b, want tens=%0d ones=%0d run=%0b exp=%0b pulse=%0b warn=%0b",
               name, $time, got.tens, got.ones, got.running, got.expired, got.pulse, got.warning,
               want.tens, want.ones, want.running, want.expired, want.pulse, want.warning);
    end
  endtask

  function automatic int clamp9(input logic [3:0] d);
    return (int'(d) > 9) ? 9 : int'(d);
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.tens    = 4'(secs / 10);
    o.ones    = 4'(secs % 10);
    o.running = (mode == M_RUN);
    o.expired = (mode == M_EXPIRED);
    o.pulse   = pulse_m;
    o.warning = WARN_EN && ((mode == M_RUN) || (mode == M_PAUSE)) && (secs < 10);
    return o;
  endfunction

  task automatic model_reset();
    secs = 0; phase = 0; mode = M_IDLE; pulse_m = 1'b0;
  endtask

  // One clock edge of the reference model, using the sampled controls.
  task automatic model_step();
    pulse_m = 1'b0;
    if (mode != M_RUN) begin
      if (load) begin
        secs  = clamp9(load_tens) * 10 + clamp9(load_ones);
        phase = 0;
        mode  = M_IDLE;
      end else if (start && (mode == M_IDLE || mode == M_PAUSE) && secs != 0) begin
        mode = M_RUN;
      end
    end else if (pause) begin
      mode = M_PAUSE;
    end else begin
      phase++;
      if (phase == CF) begin
        phase = 0;
        secs--;
        if (secs == 0) begin
          mode    = M_EXPIRED;
          pulse_m = 1'b1;
        end
      end
    end
  endtask

  // Apply controls for one cycle; predict the post-edge outputs.
  task automatic step(input bit l, input logic [3:0] lt, input logic [3:0] lo,
                      input bit s, input bit p);
    load = l; load_tens = lt; load_ones = lo; start = s; pause = p;
    @(posedge clk);
    model_step();
    exp_q.push_back(model_obs());
    @(negedge clk);
    load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset in the middle of the low clock phase.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 compare("async_reset", dut_obs(), obs_t'(0));
    @(posedge clk);
    model_reset();
    exp_q.push_back(model_obs());
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pop the prediction for each completed edge and compare.
  always @(negedge clk) begin
    if (exp_q.size() != 0) compare("cycle", dut_obs(), exp_q.pop_front());
  end

  initial begin
    int wait_cycles;
    model_reset();
    #3 compare("reset_state", dut_obs(), obs_t'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Full countdown 12 -> 00 with expiry strobe.
    step(1'b1, 4'd1, 4'd2, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    idle(50);

    // Borrow 20 -> 19, then Load while running is ignored.
    step(1'b1, 4'd2, 4'd0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    idle(4);
    step(1'b1, 4'd5, 4'd5, 1'b0, 1'b0);
    idle(3);

    // Pause keeps the divider phase; resume reaches 04 two cycles later.
    step(1'b1, 4'd0, 4'd5, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    idle(2);
    for (int i = 0; i < 10; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    idle(3);

    // Clamp to 99; start at 00 is ignored.
    step(1'b1, 4'hF, 4'hF, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    idle(2);

    // Reset at 07 mid-run; Start afterwards is ignored.
    step(1'b1, 4'd0, 4'd9, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    idle(9);
    do_reset();
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    idle(6);

    // Expired: Start ignored, Load 03 returns to IDLE.
    step(1'b1, 4'd0, 4'd1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    idle(5);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 4'd0, 4'd3, 1'b0, 1'b0);
    idle(2);

    // Randomized control traffic, biased toward short times.
    for (int i = 0; i < 1500; i++) begin
      int r;
      bit l, s, p;
      logic [3:0] lt, lo;
      r  = int'($urandom_range(0, 99));
      l  = (r < 6);
      s  = (r >= 6 && r < 16);
      p  = (r >= 16 && r < 21);
      if (r >= 21 && r < 24) s = 1'b1;
      if (r >= 21 && r < 24) p = 1'b1;
      lt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      lo = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(l, lt, lo, s, p);
    end

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
